intc_rr: RTL

Round-robin interrupt controller that collects the four factorial-unit `Done` lines and raises a single `irq` toward the MIPS core. It detects completion edges, latches them as pending, applies a software mask and arbitrates round-robin between sources. It completes an `irq`/`iack` handshake with the core and returns a vector address. Its register window sits on the memory-mapped bus next to the factorial and GPIO slaves, with the same address and write-enable style.

---
 rtl/intc_pkg.sv | 20 ++
 rtl/rr_arb4.sv | 28 ++
 rtl/intc_rr.sv | 139 +++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the round-robin interrupt controller:
// FSM encoding, register indices and STAT bit positions.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam int STAT_SVC_BIT = 8;
  localparam int STAT_ID_LSB  = 4;
  localparam int STAT_PTR_LSB = 0;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker: first request found scanning
// upward from ptr, wrapping modulo 4.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    gnt_id  = ptr;
    w_found = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        gnt_id  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/intc_rr.sv
// Round-robin interrupt controller: edge-captures Done lines into pending,
// masks, arbitrates and runs an irq/iack/EOI handshake toward the core.
//
// state | meaning
// IDLE  | no request outstanding; raise irq when a masked candidate exists
// REQ   | irq asserted, waiting for iack (drops back if candidates vanish)
// SVC   | source being serviced; no new irq until EOI is written
module intc_rr
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] Done,
  input  logic [1:0]       A,
  input  logic             WE,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  output logic             irq,
  input  logic             iack,
  output logic [31:0]      addr
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_done_q;
  logic [1:0]       r_ptr;
  logic [1:0]       r_id;
  logic             r_irq;
  logic [31:0]      r_addr;

  logic             w_wr_mask;
  logic             w_wr_pend;
  logic             w_wr_eoi;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr_w1c;
  logic [N_SRC-1:0] w_clr_ack;
  logic [N_SRC-1:0] w_mask_eff;
  logic [N_SRC-1:0] w_cand_eff;
  logic             w_cand_any_q;
  logic [1:0]       w_gnt_id;
  logic             w_arb_any;
  logic             w_ack;
  logic [31:0]      w_vec;
  logic             w_unused_wd;

  assign w_wr_mask = WE && (A == REG_MASK);
  assign w_wr_pend = WE && (A == REG_PEND);
  assign w_wr_eoi  = WE && (A == REG_EOI);

  assign w_set      = Done & ~r_done_q;
  assign w_clr_w1c  = w_wr_pend ? WD[N_SRC-1:0] : '0;
  assign w_mask_eff = w_wr_mask ? WD[N_SRC-1:0] : r_mask;

  // REQ looks at this cycle's writes so a W1C/mask change racing iack wins.
  assign w_cand_eff   = r_pend & ~w_clr_w1c & w_mask_eff;
  assign w_cand_any_q = |(r_pend & r_mask);

  rr_arb4 u_arb (
    .req    (w_cand_eff),
    .ptr    (r_ptr),
    .gnt_id (w_gnt_id),
    .any    (w_arb_any)
  );

  assign w_vec       = VEC_BASE + VEC_STRIDE * {30'd0, w_gnt_id};
  assign w_clr_ack   = w_ack ? (N_SRC'(1) << w_gnt_id) : '0;
  assign w_unused_wd = ^WD[31:N_SRC];

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cand_any_q) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!w_arb_any) begin
          w_state_nxt = ST_IDLE;
        end else if (iack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_SVC;
        end
      end
      ST_SVC: begin
        if (w_wr_eoi) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_pend   <= '0;
      r_done_q <= '0;
      r_ptr    <= 2'd0;
      r_id     <= 2'd0;
      r_irq    <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= Done;
      r_irq    <= (w_state_nxt == ST_REQ);
      if (w_wr_mask) r_mask <= WD[N_SRC-1:0];
      // New edges override any clear hitting the same bit.
      r_pend <= (r_pend & ~(w_clr_w1c | w_clr_ack)) | w_set;
      if (w_ack) begin
        r_addr <= w_vec;
        r_id   <= w_gnt_id;
        r_ptr  <= w_gnt_id + 2'd1;
      end
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      REG_MASK: RD[N_SRC-1:0] = r_mask;
      REG_PEND: RD[N_SRC-1:0] = r_pend;
      REG_STAT: begin
        RD[STAT_SVC_BIT]      = (r_state == ST_SVC);
        RD[STAT_ID_LSB +: 2]  = r_id;
        RD[STAT_PTR_LSB +: 2] = r_ptr;
      end
      default: RD = '0;
    endcase
  end

  assign irq  = r_irq;
  assign addr = r_addr;

endmodule
